// File: rtl/clk_gate_ctrl.sv
`default_nettype none
// clk_gate_ctrl: registered, glitch-free CLK_EN generator for a clock-gated unit,
// with wake-up delay before ready, idle hold-off before gating, and test override.
module clk_gate_ctrl #(
   parameter int WAKE_CYCLES = 2,
   parameter int HOLD_CYCLES = 4,
   parameter int CNT_WIDTH   = 4
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       en_req_i,
   input  logic       unit_busy_i,
   input  logic       test_en_i,
   output logic       clk_en_o,
   output logic       unit_rdy_o,
   output logic [1:0] gate_state_o
);

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      WAKE   = 2'b01,
      ACTIVE = 2'b10,
      HOLD   = 2'b11
   } state_t;

   localparam logic [CNT_WIDTH-1:0] WAKE_LOAD =
      (WAKE_CYCLES > 0) ? CNT_WIDTH'(WAKE_CYCLES - 1) : {CNT_WIDTH{1'b0}};
   localparam logic [CNT_WIDTH-1:0] HOLD_LOAD =
      (HOLD_CYCLES > 0) ? CNT_WIDTH'(HOLD_CYCLES - 1) : {CNT_WIDTH{1'b0}};
   localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

   state_t                state_q, state_d;
   logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
   logic                  clk_en_q;
   logic                  unit_rdy_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (en_req_i) begin
               if (WAKE_CYCLES > 0) begin
                  state_d = WAKE;
                  cnt_d   = WAKE_LOAD;
               end else begin
                  state_d = ACTIVE;
               end
            end
         end
         WAKE: begin
            // Wake always runs to completion; a dropped request is handled from ACTIVE.
            if (cnt_q == '0) state_d = ACTIVE;
            else             cnt_d   = cnt_q - CNT_ONE;
         end
         ACTIVE: begin
            if (!en_req_i && !unit_busy_i) begin
               if (HOLD_CYCLES > 0) begin
                  state_d = HOLD;
                  cnt_d   = HOLD_LOAD;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         HOLD: begin
            if (en_req_i || unit_busy_i) state_d = ACTIVE;
            else if (cnt_q == '0)        state_d = IDLE;
            else                         cnt_d   = cnt_q - CNT_ONE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Outputs derive from the next state so they change in step with the state register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         clk_en_q   <= 1'b0;
         unit_rdy_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         clk_en_q   <= (state_d != IDLE) | test_en_i;
         unit_rdy_q <= (state_d == ACTIVE);
      end
   end

   assign clk_en_o     = clk_en_q;
   assign unit_rdy_o   = unit_rdy_q;
   assign gate_state_o = state_q;

endmodule
`default_nettype wire

// File: tb/tb_clk_gate_ctrl.sv
`default_nettype none
// tb_clk_gate_ctrl: scoreboard bench for clk_gate_ctrl, default parameters and the
// zero-wake/zero-hold configuration side by side.
module tb_clk_gate_ctrl;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       en_req = 1'b0;
   logic       unit_busy = 1'b0;
   logic       test_en = 1'b0;
   logic       en_a, rdy_a, en_b, rdy_b;
   logic [1:0] st_a, st_b;

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      logic       req;
      logic       busy;
      logic       tst;
      logic       en;
      logic       rdy;
      logic [1:0] st;
   } vec_t;

   typedef struct {
      logic       en;
      logic       rdy;
      logic [1:0] st;
   } exp_t;

   exp_t exp_q[$];

   always #5 clk = ~clk;

   clk_gate_ctrl #(.WAKE_CYCLES(2), .HOLD_CYCLES(4), .CNT_WIDTH(4)) u_dflt (
      .clk_i(clk), .rst_ni(rst_n), .en_req_i(en_req), .unit_busy_i(unit_busy),
      .test_en_i(test_en), .clk_en_o(en_a), .unit_rdy_o(rdy_a), .gate_state_o(st_a)
   );

   clk_gate_ctrl #(.WAKE_CYCLES(0), .HOLD_CYCLES(0), .CNT_WIDTH(4)) u_zero (
      .clk_i(clk), .rst_ni(rst_n), .en_req_i(en_req), .unit_busy_i(unit_busy),
      .test_en_i(test_en), .clk_en_o(en_b), .unit_rdy_o(rdy_b), .gate_state_o(st_b)
   );

   function automatic vec_t mkv(logic req, logic busy, logic tst,
                                logic en, logic rdy, logic [1:0] st);
      vec_t v;
      v.req = req; v.busy = busy; v.tst = tst;
      v.en = en; v.rdy = rdy; v.st = st;
      return v;
   endfunction

   // Drives each vector, queues its expectation, and checks it after the next edge.
   task automatic run_dflt(string name, vec_t v[$]);
      exp_t e;
      foreach (v[i]) begin
         en_req = v[i].req; unit_busy = v[i].busy; test_en = v[i].tst;
         exp_q.push_back('{en: v[i].en, rdy: v[i].rdy, st: v[i].st});
         @(posedge clk); #1;
         e = exp_q.pop_front();
         n_cmp++;
         if (en_a !== e.en || rdy_a !== e.rdy || st_a !== e.st) begin
            n_bad++;
            $display("FAIL %s cyc%0d: got en=%b rdy=%b st=%b, want en=%b rdy=%b st=%b",
                     name, i, en_a, rdy_a, st_a, e.en, e.rdy, e.st);
         end
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0; en_req = 1'b0; unit_busy = 1'b0; test_en = 1'b0;
      @(posedge clk); #1;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      vec_t v[$];
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      n_cmp++;
      if (en_a !== 1'b0 || rdy_a !== 1'b0 || st_a !== 2'b00 ||
          en_b !== 1'b0 || rdy_b !== 1'b0 || st_b !== 2'b00) begin
         n_bad++;
         $display("FAIL reset_state: got a=%b%b%b b=%b%b%b, want 000 000",
                  en_a, rdy_a, st_a, en_b, rdy_b, st_b);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      for (int i = 0; i < 10; i++) v.push_back(mkv(0, 0, 0, 0, 0, 2'b00));
      run_dflt("idle", v);
   endtask

   task automatic test_wake();
      vec_t v[$];
      v.push_back(mkv(1, 0, 0, 1, 0, 2'b01));
      v.push_back(mkv(1, 0, 0, 1, 0, 2'b01));
      v.push_back(mkv(1, 0, 0, 1, 1, 2'b10));
      v.push_back(mkv(1, 0, 0, 1, 1, 2'b10));
      run_dflt("wake", v);
   endtask

   task automatic test_hold();
      vec_t v[$];
      for (int i = 0; i < 4; i++) v.push_back(mkv(0, 0, 0, 1, 0, 2'b11));
      v.push_back(mkv(0, 0, 0, 0, 0, 2'b00));
      v.push_back(mkv(0, 0, 0, 0, 0, 2'b00));
      v.push_back(mkv(1, 0, 0, 1, 0, 2'b01));
      v.push_back(mkv(1, 0, 0, 1, 0, 2'b01));
      v.push_back(mkv(1, 0, 0, 1, 1, 2'b10));
      for (int i = 0; i < 3; i++) v.push_back(mkv(0, 1, 0, 1, 1, 2'b10));
      for (int i = 0; i < 4; i++) v.push_back(mkv(0, 0, 0, 1, 0, 2'b11));
      v.push_back(mkv(0, 0, 0, 0, 0, 2'b00));
      run_dflt("hold", v);
   endtask

   task automatic test_rereq();
      vec_t v[$];
      v.push_back(mkv(1, 0, 0, 1, 0, 2'b01));
      v.push_back(mkv(1, 0, 0, 1, 0, 2'b01));
      v.push_back(mkv(1, 0, 0, 1, 1, 2'b10));
      v.push_back(mkv(0, 0, 0, 1, 0, 2'b11));
      v.push_back(mkv(0, 0, 0, 1, 0, 2'b11));
      v.push_back(mkv(1, 0, 0, 1, 1, 2'b10));
      v.push_back(mkv(1, 0, 0, 1, 1, 2'b10));
      v.push_back(mkv(0, 0, 0, 1, 0, 2'b11));
      v.push_back(mkv(0, 1, 0, 1, 1, 2'b10));
      for (int i = 0; i < 4; i++) v.push_back(mkv(0, 0, 0, 1, 0, 2'b11));
      v.push_back(mkv(0, 0, 0, 0, 0, 2'b00));
      run_dflt("rereq", v);
   endtask

   task automatic test_override();
      vec_t v[$];
      v.push_back(mkv(0, 0, 1, 1, 0, 2'b00));
      v.push_back(mkv(0, 0, 1, 1, 0, 2'b00));
      v.push_back(mkv(0, 0, 0, 0, 0, 2'b00));
      v.push_back(mkv(0, 1, 0, 0, 0, 2'b00));
      v.push_back(mkv(1, 0, 1, 1, 0, 2'b01));
      v.push_back(mkv(0, 0, 1, 1, 0, 2'b01));
      v.push_back(mkv(0, 1, 1, 1, 1, 2'b10));
      for (int i = 0; i < 4; i++) v.push_back(mkv(0, 0, 1, 1, 0, 2'b11));
      v.push_back(mkv(0, 0, 1, 1, 0, 2'b00));
      v.push_back(mkv(0, 0, 0, 0, 0, 2'b00));
      run_dflt("override", v);
   endtask

   task automatic test_async_reset();
      vec_t v[$];
      v.push_back(mkv(1, 0, 0, 1, 0, 2'b01));
      run_dflt("async_pre", v);
      #2;
      rst_n = 1'b0;
      #1;
      n_cmp++;
      if (en_a !== 1'b0 || rdy_a !== 1'b0 || st_a !== 2'b00) begin
         n_bad++;
         $display("FAIL async_reset: got en=%b rdy=%b st=%b, want en=0 rdy=0 st=00",
                  en_a, rdy_a, st_a);
      end
      en_req = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      v.delete();
      v.push_back(mkv(0, 0, 0, 0, 0, 2'b00));
      v.push_back(mkv(1, 0, 0, 1, 0, 2'b01));
      v.push_back(mkv(0, 0, 0, 1, 0, 2'b01));
      v.push_back(mkv(0, 0, 0, 1, 1, 2'b10));
      for (int i = 0; i < 4; i++) v.push_back(mkv(0, 0, 0, 1, 0, 2'b11));
      v.push_back(mkv(0, 0, 0, 0, 0, 2'b00));
      run_dflt("async_post", v);
   endtask

   task automatic test_zero_params();
      vec_t v[$];
      exp_t e;
      do_reset();
      v.push_back(mkv(1, 0, 0, 1, 1, 2'b10));
      v.push_back(mkv(1, 0, 0, 1, 1, 2'b10));
      v.push_back(mkv(0, 1, 0, 1, 1, 2'b10));
      v.push_back(mkv(0, 0, 0, 0, 0, 2'b00));
      v.push_back(mkv(0, 0, 1, 1, 0, 2'b00));
      v.push_back(mkv(1, 0, 0, 1, 1, 2'b10));
      v.push_back(mkv(0, 0, 0, 0, 0, 2'b00));
      foreach (v[i]) begin
         en_req = v[i].req; unit_busy = v[i].busy; test_en = v[i].tst;
         exp_q.push_back('{en: v[i].en, rdy: v[i].rdy, st: v[i].st});
         @(posedge clk); #1;
         e = exp_q.pop_front();
         n_cmp++;
         if (en_b !== e.en || rdy_b !== e.rdy || st_b !== e.st) begin
            n_bad++;
            $display("FAIL zero_params cyc%0d: got en=%b rdy=%b st=%b, want en=%b rdy=%b st=%b",
                     i, en_b, rdy_b, st_b, e.en, e.rdy, e.st);
         end
      end
      en_req = 1'b0; unit_busy = 1'b0; test_en = 1'b0;
   endtask

   initial begin
      test_reset();
      test_wake();
      test_hold();
      test_rereq();
      test_override();
      test_async_reset();
      test_zero_params();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
